// File: rtl/obi_sram_responder.sv
// rtl/obi_sram_responder.sv - OBI subordinate with word-addressed byte-enable SRAM and grant wait states
//
// Purpose:
//   Terminates one OBI slave port with an internal memory of NUM_WORDS x 32 bits.
//   Each new request is stalled by a programmable number of grant wait states
//   (wait_cycles_i, sampled on the first request cycle). Every handshake gets
//   exactly one response, registered, one cycle after the grant. Requests outside
//   [BASE_ADDR, BASE_ADDR + NUM_WORDS*4) are still answered: writes are dropped,
//   reads return OOB_RDATA, and a saturating error counter increments.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset (memory contents are not reset)
//   slave_req_i    OBI request: req, we, be[3:0], addr[31:0], wdata[31:0]
//   slave_resp_o   OBI response: gnt (combinational), rvalid, rdata[31:0] (registered)
//   wait_cycles_i  grant wait states for the next new request
//   oob_o          pulse alongside rvalid of an out-of-window response
//   oob_cnt_o      saturating count of out-of-window handshakes

package obi_sram_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_sram_responder
  import obi_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] OOB_RDATA = 32'hBADA_CCE5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    slave_req_i,
  output obi_resp_t   slave_resp_o,
  input  logic [3:0]  wait_cycles_i,
  output logic        oob_o,
  output logic [15:0] oob_cnt_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);

  typedef enum logic {
    IDLE,
    STALL
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        oob_q;
  logic [15:0] oob_cnt_q;

  logic [31:0] mem_q [NUM_WORDS];

  logic [31:0]   offset;
  logic          in_win;
  logic [AW-1:0] idx;
  logic          gnt;
  logic          hs;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap to a huge offset,
  // so they fall out of the window without a separate lower-bound compare.
  assign offset = slave_req_i.addr - BASE_ADDR;
  assign in_win = (offset >> (AW + 2)) == 32'd0;
  assign idx    = offset[AW+1:2];

  // Grant immediately from IDLE when no wait states are requested, otherwise
  // only when the STALL countdown has expired.
  assign gnt = slave_req_i.req &&
               (((state_q == IDLE) && (wait_cycles_i == 4'd0)) ||
                ((state_q == STALL) && (cnt_q == 4'd0)));
  assign hs  = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      oob_q     <= 1'b0;
      oob_cnt_q <= 16'd0;
    end else begin
      rvalid_q <= hs;
      oob_q    <= hs && !in_win;

      if (hs) begin
        if (slave_req_i.we) begin
          rdata_q <= 32'd0;
        end else if (in_win) begin
          rdata_q <= mem_q[idx];
        end else begin
          rdata_q <= OOB_RDATA;
        end
      end

      if (hs && !in_win && (oob_cnt_q != 16'hFFFF)) begin
        oob_cnt_q <= oob_cnt_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          if (slave_req_i.req && (wait_cycles_i != 4'd0)) begin
            cnt_q   <= wait_cycles_i - 4'd1;
            state_q <= STALL;
          end
        end
        STALL: begin
          // A master that withdraws req mid-stall gets nothing; restart cleanly.
          if (!slave_req_i.req) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory has no reset so its contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (hs && slave_req_i.we && in_win) begin
      for (int j = 0; j < 4; j++) begin
        if (slave_req_i.be[j]) begin
          mem_q[idx][8*j +: 8] <= slave_req_i.wdata[8*j +: 8];
        end
      end
    end
  end

  assign slave_resp_o.gnt    = gnt;
  assign slave_resp_o.rvalid = rvalid_q;
  assign slave_resp_o.rdata  = rdata_q;
  assign oob_o               = oob_q;
  assign oob_cnt_o           = oob_cnt_q;

endmodule
